cmp_sequencer: RTL
==================

// Module: cmp_sequencer
// PURPOSE
//  Multi-cycle signed/unsigned 32-bit magnitude comparator for area-constrained core builds.
//  Feeds one narrow combinational slice comparator, MSB-slice first, and stops on the first unequal slice.
//  Serves branch-resolve and SLT/SLTU requests through a valid/ready request/response handshake.
//  Signed compares invert operand bit WIDTH-1 before comparison, so one unsigned slice serves both modes.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of SLICE
//  SLICE  8   bits compared per cycle
//  NSLICE WIDTH/SLICE (localparam)  slice count; index counter is $clog2(NSLICE) bits
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Reset_n    in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept a request; high only in IDLE
//  A          in   WIDTH  operand A, sampled on accept
//  B          in   WIDTH  operand B, sampled on accept
//  Signed     in   1      1 = two's-complement compare, 0 = unsigned; sampled on accept
//  flush      in   1      synchronous abort of any in-flight compare
//  rsp_valid  out  1      result valid; high only in DONE
//  rsp_ready  in   1      consumer takes the result
//  GT,LT,EQ   out  1 each  A>B, A<B, A==B; exactly one is high while rsp_valid=1
//  cmp_cycles out  $clog2(NSLICE)+1  CMP cycles used by the current result (1..NSLICE)
// BEHAVIOUR
//  Reset (Reset_n low, async): state=IDLE, rsp_valid=0, GT=LT=EQ=0, cmp_cycles=0, idx=NSLICE-1.
//   req_ready=1 once Reset_n is high.
//  FSM states: IDLE, CMP, DONE. Registered outputs; req_ready/rsp_valid decode state.
//  IDLE: accept when req_valid&req_ready. Latch A,B with bit WIDTH-1 inverted if Signed.
//   idx<=NSLICE-1, cmp_cycles<=0 -> CMP.
//  CMP: compare latched slice [idx*SLICE +: SLICE]; cmp_cycles++.
//   slice A>B or A<B: set GT/LT, EQ=0 -> DONE.
//   slice equal, idx==0: EQ=1 -> DONE.
//   slice equal, idx>0: idx-- and stay in CMP.
//  DONE: hold GT/LT/EQ/cmp_cycles stable while rsp_ready=0.
//   On rsp_valid&rsp_ready -> IDLE; flags stay at last value; no new accept in the same cycle.
//  Latency: accept in cycle N; rsp_valid high from cycle N+1+k, k = slices examined (1..NSLICE).
//   Minimum initiation interval is k+2 cycles.
//  flush: highest priority over accept, CMP and DONE; next state IDLE, rsp_valid=0 next cycle.
//   In-flight result is discarded. flush in IDLE is ignored, and a req_valid in that cycle is not accepted.
//  Reset mid-operation: immediate return to reset values; no response is produced.
//  A,B,Signed changing after accept have no effect; only latched copies are used.
//  Width rules: slice compare is unsigned SLICE-bit. The sign fix applies only to bit WIDTH-1 (top slice).
// STRUCTURE
//  Shared package cmp_pkg: state encoding constants (CMP_IDLE/CMP_CMP/CMP_DONE)
//   and default WIDTH/SLICE constants.
//  One sub-module: magcompare_slice #(SLICE) -- combinational unsigned GT/LT/EQ on SLICE-bit inputs.
//  Top holds the FSM, idx counter, operand registers, slice mux and result registers.
// TESTING
//  1 A=0056eecd B=0056eecd Signed=1 -> EQ=1, cmp_cycles=4, rsp_valid at accept+5.
//  2 A=74c8b8dc B=23bebdfe Signed=0 -> GT=1, cmp_cycles=1, rsp_valid at accept+2.
//  3 A=46f63068 B=dade4fde Signed=1 -> GT=1; same operands with Signed=0 -> LT=1; both cmp_cycles=1.
//  4 A=12340000 B=12350000 unsigned -> LT=1, cmp_cycles=2.
//    Then hold rsp_ready=0 for 3 cycles -> outputs stable, req_ready=0.
//  5 Case 1 operands, flush asserted in 2nd CMP cycle -> no rsp_valid pulse; req_ready=1 next cycle.
//    Next request A=0 B=1 -> LT.
//  6 Reset_n pulsed low mid-CMP, and req_valid+flush in IDLE -> reset values asynchronously.
//    No accept in the flush cycle; check GT/LT/EQ against a $signed/unsigned reference model over 1000 random pairs.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants for the sequential magnitude comparator.
// Holds the default operand/slice widths and the FSM state encoding.
// Imported by cmp_sequencer and magcompare_slice.
package cmp_pkg;

  localparam int CMP_WIDTH = 32;
  localparam int CMP_SLICE = 8;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_CMP  = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/magcompare_slice.sv
// Purpose: unsigned GT/LT/EQ compare of one SLICE-bit operand pair.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns all sequencing.
module magcompare_slice
  import cmp_pkg::*;
#(
  parameter int SLICE = CMP_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/cmp_sequencer.sv
// Purpose: multi-cycle signed/unsigned magnitude compare, one slice per cycle, MSB slice first.
// Latency: result valid 1+k cycles after accept, k = slices examined (1..NSLICE).
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready; flush aborts.
module cmp_sequencer
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int SLICE = CMP_SLICE
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [WIDTH-1:0]                A,
  input  logic [WIDTH-1:0]                B,
  input  logic                            Signed,
  input  logic                            flush,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            GT,
  output logic                            LT,
  output logic                            EQ,
  output logic [$clog2(WIDTH/SLICE):0]    cmp_cycles
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = $clog2(NSLICE);
  localparam int CW     = IW + 1;

  cmp_state_t        state;
  cmp_state_t        state_nxt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [IW-1:0]     idx;
  logic [SLICE-1:0]  a_sl;
  logic [SLICE-1:0]  b_sl;
  logic              sl_gt;
  logic              sl_lt;
  logic              sl_eq;
  logic              accept;
  logic [WIDTH-1:0]  sign_mask;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so a single unsigned slice comparator serves both modes.
  assign sign_mask = {Signed, {(WIDTH-1){1'b0}}};

  assign req_ready = (state == CMP_IDLE) && Reset_n;
  assign rsp_valid = (state == CMP_DONE);
  // A flush in IDLE blocks the accept in the same cycle.
  assign accept    = req_valid && req_ready && !flush;

  assign a_sl = a_q[idx*SLICE +: SLICE];
  assign b_sl = b_q[idx*SLICE +: SLICE];

  magcompare_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .gt (sl_gt),
    .lt (sl_lt),
    .eq (sl_eq)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CMP_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = CMP_IDLE;
    end else begin
      case (state)
        CMP_IDLE: if (accept)              state_nxt = CMP_CMP;
        CMP_CMP:  if (!sl_eq || idx == '0) state_nxt = CMP_DONE;
        CMP_DONE: if (rsp_ready)           state_nxt = CMP_IDLE;
        default:                           state_nxt = CMP_IDLE;
      endcase
    end
  end

  // Operand capture, slice index walk and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= IW'(NSLICE - 1);
      cmp_cycles <= '0;
      GT         <= 1'b0;
      LT         <= 1'b0;
      EQ         <= 1'b0;
    end else if (!flush) begin
      case (state)
        CMP_IDLE: begin
          if (accept) begin
            a_q        <= A ^ sign_mask;
            b_q        <= B ^ sign_mask;
            idx        <= IW'(NSLICE - 1);
            cmp_cycles <= '0;
          end
        end
        CMP_CMP: begin
          cmp_cycles <= cmp_cycles + CW'(1);
          if (!sl_eq) begin
            GT <= sl_gt;
            LT <= sl_lt;
            EQ <= 1'b0;
          end else if (idx == '0) begin
            GT <= 1'b0;
            LT <= 1'b0;
            EQ <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
